uart_rx_mmio: RTL and testbench

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_mmio.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART receiver: register offsets,
// STATUS bit layout and receiver FSM state encodings.
package uart_pkg;

  localparam logic [2:0] DATA_OFS   = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int ST_NE    = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_CNT   = 4;
  localparam int ST_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, power-of-two depth, first-word-fall-through head.
// A pop on a full FIFO frees the slot the same-cycle push lands in.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_pop;
  logic         do_push;

  assign count   = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rp[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with FIFO and MMIO DATA/STATUS registers.
// Define UART_RX_MAJORITY_EN for 3-sample majority bit voting.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0010,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        uart_ready,
  output logic [31:0] mmio_rdata,
  output logic        rx_irq_o
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned LAG = 1;
`else
  localparam int unsigned LAG = 0;
`endif
  localparam int unsigned CNT_W = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'(BIT_CYC / 2 - 1 + LAG);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(BIT_CYC - 1);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  logic [1:0] sync;
  logic       rx_s;
  logic       rx_q;
  logic       bit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[0], rx_pin};
      rx_q <= rx_s;
    end
  end

  assign rx_s = sync[1];

`ifdef UART_RX_MAJORITY_EN
  // Decision is taken one cycle late so the window is centred.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign bit_val = maj3(rx_s, hist[0], hist[1]);
`else
  assign bit_val = rx_s;
`endif

  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_wait;
  logic             push_q;
  logic             ferr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_wait <= 1'b0;
      push_q    <= 1'b0;
      ferr_set  <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      ferr_set <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_q && !rx_s) begin
            state   <= S_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= bit_val ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {bit_val, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (stop_wait) begin
            if (rx_s) begin
              stop_wait <= 1'b0;
              state     <= S_IDLE;
            end
          end else if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (bit_val) begin
              push_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              ferr_set  <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic          sel;
  logic          is_status;
  logic          rd_data;
  logic          rd_status;
  logic          clr;
  logic          pop;
  logic          ovr_set;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [FAW:0]  fifo_count;
  logic          ovr;
  logic          ferr;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign sel       = bus_valid &&
                     (bus_addr[31:3] == BASE_ADDR[31:3]);
  assign uart_ready = sel && rst_n;
  assign is_status = (bus_addr[2] == STATUS_OFS[2]);
  assign rd_data   = sel && !bus_write && !is_status;
  assign rd_status = sel && !bus_write && is_status;
  assign clr       = sel && bus_write && is_status;
  assign pop       = rd_data && !empty;
  assign ovr_set   = push_q && full && !pop;
  assign rx_irq_o  = !empty;
  assign unused_bits = ^{bus_wdata[31:4], bus_wdata[1:0],
                         bus_addr[1:0]};

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (shreg),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Sticky flags: a same-cycle set beats the write-one-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set ||
              (ovr && !(clr && bus_wdata[ST_OVR]));
      ferr <= ferr_set ||
              (ferr && !(clr && bus_wdata[ST_FERR]));
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_NE]   = !empty;
    status_word[ST_FULL] = full;
    status_word[ST_OVR]  = ovr;
    status_word[ST_FERR] = ferr;
    status_word[ST_CNT +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    mmio_rdata = '0;
    unique case (1'b1)
      rd_status:         mmio_rdata = status_word;
      rd_data && !empty: mmio_rdata = {24'b0, head};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed + randomized bench for uart_rx_mmio against a queue model.
// Bit period shortened to 250 clocks at 115200 baud to bound runtime.
module tb_uart_rx_mmio;

  localparam int unsigned CLK_FREQ = 28_800_000;
  localparam int unsigned BAUD     = 115200;
  localparam int          BIT      = CLK_FREQ / BAUD;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h1000_0010;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_STAT   = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        uart_ready;
  logic [31:0] mmio_rdata;
  logic        rx_irq_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tx_done = 1'b1;

  logic [7:0] q[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  uart_rx_mmio #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .uart_ready (uart_ready),
    .mmio_rdata (mmio_rdata),
    .rx_irq_o   (rx_irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_status();
    int n;
    n = q.size();
    return {23'b0, n[4:0], m_ferr, m_ovr,
            (n == DEPTH), (n != 0)};
  endfunction

  function automatic void model_rx(logic [7:0] b, bit stop_ok);
    if (!stop_ok)              m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else                        q.push_back(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit stop);
    tx_done = 1'b0;
    rx_pin = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) tick();
    end
    rx_pin = stop;
    repeat (BIT) tick();
    rx_pin = 1'b1;
    repeat (stop ? 4 : BIT) tick();
    tx_done = 1'b1;
  endtask

  task automatic rd(logic [31:0] a, output logic [31:0] d,
                    output logic rdy);
    bus_valid = 1'b1;
    bus_write = 1'b0;
    bus_addr  = a;
    #1;
    d   = mmio_rdata;
    rdy = uart_ready;
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] v);
    bus_valid = 1'b1;
    bus_write = 1'b1;
    bus_addr  = a;
    bus_wdata = v;
    #1;
    chk("wr_ready", uart_ready, 1);
    tick();
    bus_valid = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic chk_status(string tag);
    logic [31:0] d;
    logic        r;
    rd(A_STAT, d, r);
    chk(tag, d, exp_status());
  endtask

  task automatic chk_data(string tag);
    logic [31:0] d;
    logic [31:0] e;
    logic        r;
    rd(A_DATA, d, r);
    e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'h0;
    chk(tag, d, e);
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 12 * BIT && !tx_done; i++) tick();
    chk("tx_done", tx_done, 1);
  endtask

  initial begin
    logic [31:0] d;
    logic        r;
    logic [7:0]  b;
    int          s;
    int          k;
    int          lat;

    bus_valid = 1'b1;
    bus_addr  = A_DATA;
    repeat (3) tick();
    chk("ready_in_reset", uart_ready, 0);
    chk("irq_reset", rx_irq_o, 0);
    bus_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk_status("status_reset");
    chk_data("empty_read");
    rd(BASE + 32'h8, d, r);
    chk("unsel_data", d, 0);
    chk("unsel_ready", r, 0);

    // Frame 0x55; also measures start-to-push latency.
    s = cyc;
    fork send_frame(8'h55, 1'b1); join_none
    bus_valid = 1'b1;
    bus_addr  = A_STAT;
    k = -1;
    for (int i = 0; i < 12 * BIT && k < 0; i++) begin
      tick();
      if (mmio_rdata[0]) k = cyc;
    end
    bus_valid = 1'b0;
    chk("push_seen", (k >= 0), 1);
    lat = k - s;
    model_rx(8'h55, 1'b1);
    chk("st_0x55", mmio_rdata, 32'h11);
    chk("irq_0x55", rx_irq_o, 1);
    wait_tx();
    rd(A_DATA, d, r);
    chk("ready_data", r, 1);
    chk("data_0x55", d, {24'b0, q.pop_front()});
    chk_status("st_after_0x55");
    chk("irq_clear", rx_irq_o, 0);

    rx_pin = 1'b0;
    repeat (100) tick();
    rx_pin = 1'b1;
    repeat (BIT) tick();
    chk_status("st_glitch");

    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_rx(b, 1'b1);
      chk_status("st_rand");
      if ($urandom_range(0, 1) == 1) chk_data("data_rand");
      repeat ($urandom_range(0, BIT)) tick();
    end
    while (q.size() != 0) chk_data("drain_rand");
    chk_status("st_rand_end");

    send_frame(8'hA3, 1'b0);
    model_rx(8'hA3, 1'b0);
    chk_status("st_ferr");
    send_frame(8'h3C, 1'b1);
    model_rx(8'h3C, 1'b1);
    chk_status("st_ferr_rx");
    chk_data("data_0x3c");
    wr(A_STAT, 32'h8);
    m_ferr = 1'b0;
    chk_status("st_ferr_clr");

    for (int n = 0; n <= 16; n++) begin
      send_frame(8'(n), 1'b1);
      model_rx(8'(n), 1'b1);
    end
    chk_status("st_ovr");
    wr(A_STAT, 32'h4);
    m_ovr = 1'b0;
    chk_status("st_ovr_clr");
    wr(A_DATA, 32'hFF);
    chk_status("st_data_wr");

    // Stop-bit push lands on the same edge as a DATA pop.
    s = cyc;
    fork send_frame(8'h11, 1'b1); join_none
    for (int i = 0; i < 12 * BIT && cyc < s + lat - 1; i++)
      tick();
    bus_valid = 1'b1;
    bus_addr  = A_DATA;
    #1;
    d = mmio_rdata;
    tick();
    bus_valid = 1'b0;
    chk("data_coinc", d, {24'b0, q.pop_front()});
    model_rx(8'h11, 1'b1);
    chk_status("st_coinc");
    wait_tx();
    while (q.size() != 0) chk_data("drain_full");
    chk_status("st_drained");

    send_frame(8'h77, 1'b1);
    model_rx(8'h77, 1'b1);
    chk_status("st_pre_rst");
    s = cyc;
    fork send_frame(8'hF3, 1'b1); join_none
    for (int i = 0; i < 12 * BIT && cyc < s + 5 * BIT + BIT / 2; i++)
      tick();
    rst_n = 1'b0;
    bus_valid = 1'b1;
    bus_addr  = A_DATA;
    #1;
    chk("ready_mid_rst", uart_ready, 0);
    chk("irq_mid_rst", rx_irq_o, 0);
    repeat (3) tick();
    bus_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    wait_tx();
    repeat (BIT) tick();
    chk_status("st_post_rst");
    chk("irq_post_rst", rx_irq_o, 0);

    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_rx(b, 1'b1);
    chk_status("st_resume");
    chk_data("data_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
